// File: rtl/fetch_decode_stage_if.sv
// rtl/fetch_decode_stage_if.sv - fetch/decode stage control and pipeline-register bus
interface fetch_decode_stage_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        MisalignD;

  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignD
  );

  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignD
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - RV32I program counter and IF/ID pipeline register
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_stage_if.slave  bus
);

  logic [31:0] r_pcf;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;
  logic        r_misalign_d;
  logic [31:0] w_pcplus4_f;

  assign w_pcplus4_f = r_pcf + 32'd4;

  // A redirect wins over a fetch stall so a taken branch is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcf <= RESET_PC;
    end else if (bus.PCSrcE) begin
      r_pcf <= bus.PCTargetE;
    end else if (!bus.StallF) begin
      r_pcf <= w_pcplus4_f;
    end
  end

  // Flush loads constants only, so an undefined InstrF cannot leak into decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pcplus4_d  <= 32'd0;
      r_valid_d    <= 1'b0;
      r_misalign_d <= 1'b0;
    end else if (bus.FlushD) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pcplus4_d  <= 32'd0;
      r_valid_d    <= 1'b0;
      r_misalign_d <= 1'b0;
    end else if (!bus.StallD) begin
      r_instr_d    <= bus.InstrF;
      r_pc_d       <= r_pcf;
      r_pcplus4_d  <= w_pcplus4_f;
      r_valid_d    <= 1'b1;
      r_misalign_d <= (r_pcf[1:0] != 2'b00);
    end
  end

  assign bus.PCF       = r_pcf;
  assign bus.InstrD    = r_instr_d;
  assign bus.PCD       = r_pc_d;
  assign bus.PCPlus4D  = r_pcplus4_d;
  assign bus.ValidD    = r_valid_d;
  assign bus.MisalignD = r_misalign_d;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - randomized self-checking bench for fetch_decode_stage
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  fetch_decode_stage_if bus();

  fetch_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what fetch and decode should hold right now.
  logic [31:0] m_pcf;
  logic [31:0] m_instr_d;
  logic [31:0] m_pc_d;
  logic [31:0] m_pc4_d;
  logic        m_valid_d;
  logic        m_mis_d;

  task automatic model_reset();
    m_pcf     = 32'h0;
    m_instr_d = NOP;
    m_pc_d    = 32'h0;
    m_pc4_d   = 32'h0;
    m_valid_d = 1'b0;
    m_mis_d   = 1'b0;
  endtask

  task automatic drive_idle();
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.PCSrcE    = 1'b0;
    bus.PCTargetE = 32'h0;
  endtask

  // Advance one clock; the model applies the pipeline rules to the inputs held over the edge.
  task automatic step();
    logic [31:0] n_pc, n_instr, n_pcd, n_pc4;
    logic        n_valid, n_mis;
    if (bus.PCSrcE)      n_pc = bus.PCTargetE;
    else if (bus.StallF) n_pc = m_pcf;
    else                 n_pc = 32'((64'(m_pcf) + 64'd4) % 64'h1_0000_0000);
    n_instr = m_instr_d; n_pcd = m_pc_d; n_pc4 = m_pc4_d; n_valid = m_valid_d; n_mis = m_mis_d;
    if (bus.FlushD) begin
      n_instr = NOP; n_pcd = 0; n_pc4 = 0; n_valid = 0; n_mis = 0;
    end else if (!bus.StallD) begin
      n_instr = bus.InstrF;
      n_pcd   = m_pcf;
      n_pc4   = 32'((64'(m_pcf) + 64'd4) % 64'h1_0000_0000);
      n_valid = 1'b1;
      n_mis   = (m_pcf % 4) != 0;
    end
    @(posedge clk);
    #1;
    m_pcf = n_pc; m_instr_d = n_instr; m_pc_d = n_pcd; m_pc4_d = n_pc4;
    m_valid_d = n_valid; m_mis_d = n_mis;
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.PCF !== 32'h0 || bus.InstrD !== NOP || bus.PCD !== 32'h0 ||
        bus.PCPlus4D !== 32'h0 || bus.ValidD !== 1'b0 || bus.MisalignD !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b MisalignD=%b, expected 0/%h/0/0/0/0",
               bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD, bus.MisalignD, NOP);
    end
  endtask

  task automatic test_free_run();
    drive_idle();
    bus.InstrF = 32'h0050_0093;
    step();
    tests_run++;
    if (bus.PCF !== 32'h4 || bus.InstrD !== 32'h0050_0093 || bus.PCD !== 32'h0 ||
        bus.PCPlus4D !== 32'h4 || bus.ValidD !== 1'b1) begin
      tests_failed++;
      $display("FAIL free_run_first: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, expected 4/00500093/0/4/1",
               bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD);
    end
    step();
    tests_run++;
    if (bus.PCF !== 32'h8 || bus.PCD !== 32'h4 || bus.PCPlus4D !== 32'h8) begin
      tests_failed++;
      $display("FAIL free_run_second: PCF=%h PCD=%h PCPlus4D=%h, expected 8/4/8", bus.PCF, bus.PCD, bus.PCPlus4D);
    end
  endtask

  task automatic test_stall();
    bus.StallF = 1'b1;
    bus.StallD = 1'b1;
    bus.InstrF = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (bus.PCF !== 32'h8 || bus.PCD !== 32'h4 || bus.InstrD !== 32'h0050_0093) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: PCF=%h PCD=%h InstrD=%h, expected 8/4/00500093", i, bus.PCF, bus.PCD, bus.InstrD);
      end
    end
    drive_idle();
    step();
    tests_run++;
    if (bus.PCF !== 32'hC || bus.PCD !== 32'h8 || bus.InstrD !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL stall_release: PCF=%h PCD=%h InstrD=%h, expected c/8/deadbeef", bus.PCF, bus.PCD, bus.InstrD);
    end
  endtask

  task automatic test_redirect_flush();
    bus.StallF    = 1'b1;
    bus.StallD    = 1'b1;
    bus.FlushD    = 1'b1;
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'h100;
    bus.InstrF    = 32'hxxxx_xxxx;
    step();
    tests_run++;
    if (bus.PCF !== 32'h100 || bus.InstrD !== NOP || bus.ValidD !== 1'b0 ||
        bus.PCD !== 32'h0 || bus.PCPlus4D !== 32'h0 || bus.MisalignD !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_flush: PCF=%h InstrD=%h ValidD=%b PCD=%h PCPlus4D=%h, expected 100/%h/0/0/0",
               bus.PCF, bus.InstrD, bus.ValidD, bus.PCD, bus.PCPlus4D, NOP);
    end
    drive_idle();
    bus.InstrF = 32'h0000_0033;
  endtask

  task automatic test_misalign();
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'h102;
    step();
    tests_run++;
    if (bus.PCF !== 32'h102) begin
      tests_failed++;
      $display("FAIL misalign_target: PCF=%h, expected 102", bus.PCF);
    end
    drive_idle();
    step();
    tests_run++;
    if (bus.MisalignD !== 1'b1 || bus.PCD !== 32'h102 || bus.PCPlus4D !== 32'h106 || bus.PCF !== 32'h106) begin
      tests_failed++;
      $display("FAIL misalign_capture: MisalignD=%b PCD=%h PCPlus4D=%h PCF=%h, expected 1/102/106/106",
               bus.MisalignD, bus.PCD, bus.PCPlus4D, bus.PCF);
    end
    step();
    tests_run++;
    if (bus.MisalignD !== 1'b1 || bus.PCD !== 32'h106) begin
      tests_failed++;
      $display("FAIL misalign_sequential: MisalignD=%b PCD=%h, expected 1/106", bus.MisalignD, bus.PCD);
    end
  endtask

  task automatic test_wrap();
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'hFFFF_FFFC;
    step();
    drive_idle();
    step();
    tests_run++;
    if (bus.PCF !== 32'h0 || bus.PCD !== 32'hFFFF_FFFC || bus.PCPlus4D !== 32'h0 || bus.MisalignD !== 1'b0) begin
      tests_failed++;
      $display("FAIL pc_wrap: PCF=%h PCD=%h PCPlus4D=%h MisalignD=%b, expected 0/fffffffc/0/0",
               bus.PCF, bus.PCD, bus.PCPlus4D, bus.MisalignD);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      bus.StallF    = ($urandom_range(0, 3) == 0);
      bus.StallD    = ($urandom_range(0, 3) == 0);
      bus.FlushD    = ($urandom_range(0, 5) == 0);
      bus.PCSrcE    = ($urandom_range(0, 6) == 0);
      bus.PCTargetE = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.InstrF    = $urandom;
      step();
      tests_run++;
      if (bus.PCF !== m_pcf || bus.InstrD !== m_instr_d || bus.PCD !== m_pc_d ||
          bus.PCPlus4D !== m_pc4_d || bus.ValidD !== m_valid_d || bus.MisalignD !== m_mis_d) begin
        tests_failed++;
        if (bad < 5)
          $display("FAIL random[%0d]: got PCF=%h InstrD=%h PCD=%h PC4D=%h V=%b M=%b, expected %h/%h/%h/%h/%b/%b",
                   i, bus.PCF, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD, bus.MisalignD,
                   m_pcf, m_instr_d, m_pc_d, m_pc4_d, m_valid_d, m_mis_d);
        bad++;
      end
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'h40;
    bus.InstrF    = 32'h0010_0113;
    step();
    drive_idle();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (bus.PCF !== 32'h0 || bus.InstrD !== NOP || bus.ValidD !== 1'b0 || bus.PCD !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: PCF=%h InstrD=%h ValidD=%b PCD=%h, expected 0/%h/0/0",
               bus.PCF, bus.InstrD, bus.ValidD, bus.PCD, NOP);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    tests_run++;
    if (bus.PCF !== 32'h4 || bus.PCD !== 32'h0 || bus.ValidD !== 1'b1 || bus.InstrD !== 32'h0010_0113) begin
      tests_failed++;
      $display("FAIL post_reset_fetch: PCF=%h PCD=%h ValidD=%b InstrD=%h, expected 4/0/1/00100113",
               bus.PCF, bus.PCD, bus.ValidD, bus.InstrD);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    drive_idle();
    bus.InstrF   = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_flush();
    test_misalign();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
